// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID constants: bus widths, zero/NOP words, control levels.
// Imported by the fetch/decode buffer and its storage array.
package if_id_buffer_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [31:0] ZeroWord = 32'h0;
    localparam logic [31:0] NopInst  = 32'h0;

    localparam logic RstEnable  = 1'b1;
    localparam logic ChipEnable = 1'b1;

endpackage

// File: rtl/if_id_fifo_mem.sv
// Register array for the IF/ID buffer: one write port, async read port.
// The array has no reset; entries are meaningless until written.
module if_id_fifo_mem
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = InstAddrBus + InstBus,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO; empty buffer presents an all-zero word to decode.
// Define IF_ID_STATS_EN to add the saturating stall_cnt output.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int PC_W   = InstAddrBus,
    parameter int INST_W = InstBus,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready
`ifdef IF_ID_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = PC_W + INST_W;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;

    // Full blocks fetch even on a pop: no same-cycle pass-through.
    assign if_ready = (count != FULL_CNT) & ~rst;
    assign id_valid = (count != '0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    assign id_pc   = id_valid ? head[W-1:INST_W] : '0;
    assign id_inst = id_valid ? head[INST_W-1:0] : '0;

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata ({if_pc, if_inst}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef IF_ID_STATS_EN
    // Flush is a redirect, not a stats event, so only rst clears.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt <= '0;
        end else if (if_valid & ~if_ready) begin
            if (stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
